buffer_drain: RTL and testbench
===============================

BUFFER_DRAIN -- requirements
Module: buffer_drain

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one output word.
REQ-002 SHALL have parameter DEPTH, default 2, number of words per input block (DEPTH >= 2).
REQ-003 SHALL have port clk  input  1  the clock; one clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous abort; discards any held block.
REQ-006 SHALL have port i_data  input  DATA_W*DEPTH  parallel block; word k = bits [k*DATA_W +: DATA_W].
REQ-007 SHALL have port i_valid  input  1  i_data valid.
REQ-008 SHALL have port o_ready  output  1  block accepted when i_valid & o_ready.
REQ-009 SHALL have port o_data  output  DATA_W  serial output word.
REQ-010 SHALL have port o_valid  output  1  o_data valid.
REQ-011 SHALL have port i_ready  input  1  downstream accepts word when o_valid & i_ready.
REQ-012 SHALL have port o_last  output  1  high with o_valid on word DEPTH-1 of a block.

Function
REQ-013 SHALL be the parallel-in/serial-out counterpart of the shift-in buffer: one DEPTH-word block in, DEPTH words out, word 0 first.
REQ-014 SHALL implement a two-state FSM: IDLE (no block held) and SEND (block held, words pending).
REQ-015 IDLE: o_ready=1, o_valid=0; on i_valid, SHALL latch i_data into a block register, set word counter to 0, go to SEND.
REQ-016 SEND: o_valid=1, o_data = held word[counter], o_last = (counter == DEPTH-1).
REQ-017 SEND, i_ready=1, counter < DEPTH-1: SHALL increment counter.
REQ-018 SEND, i_ready=1, counter == DEPTH-1: SHALL assert o_ready combinationally; if i_valid, latch new block, counter=0, stay SEND (zero-bubble); else go to IDLE.
REQ-019 SEND, counter < DEPTH-1, or i_ready=0: o_ready SHALL be 0.
REQ-020 While o_valid & !i_ready, o_data, o_last and counter SHALL hold stable.
REQ-021 Latency: block accepted at edge N -> word 0 valid in cycle after edge N; sustained throughput one word per cycle with i_ready held high.
REQ-022 Counter width SHALL be clog2(DEPTH) bits; it never exceeds DEPTH-1, no wrap past last word.
REQ-023 clear=1 SHALL, at next edge, force IDLE and counter 0, regardless of i_valid/i_ready; during the clear cycle o_ready SHALL be 0, so no block is accepted.
REQ-024 clear in IDLE SHALL be a no-op beyond REQ-023.
REQ-025 Block register contents need not be cleared; o_data is don't-care while o_valid=0.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, counter 0, block register 0.
REQ-027 Outputs under reset: o_valid=0, o_last=0, o_data=0, o_ready=1 (forced to 0 while rst asserted is NOT required; o_ready follows IDLE).
REQ-028 Reset mid-block SHALL discard remaining words; no word emitted after rst deasserts until a new block is accepted.

Structure
REQ-029 FSM state encodings (IDLE=0, SEND=1) SHALL live in the shared project definitions header, not local to the module.
REQ-030 Word counter SHALL be a sub-module drain_ctr (clk, rst, clear, load, step, o_cnt, o_last), mirroring the existing buffer counter.
REQ-031 Word selection from block register SHALL be a combinational indexed slice; no additional pipeline stage.

Verification
REQ-032 DEPTH=2: block {0xBBBB_BBBB,0xAAAA_AAAA} with i_ready=1 -> o_data 0xAAAA_AAAA then 0xBBBB_BBBB on consecutive cycles, o_last high on second only.
REQ-033 Back-to-back: second block presented on last-word cycle, i_ready=1 -> o_ready=1 that cycle, four words in four consecutive cycles, no o_valid gap.
REQ-034 Backpressure: i_ready low 3 cycles on word 0 -> o_data holds 0xAAAA_AAAA, o_valid stays 1, o_ready 0; resumes on i_ready.
REQ-035 clear asserted during word 0 with i_valid=1 -> next cycle IDLE, o_valid=0, new block not accepted that cycle, o_ready=1 after.
REQ-036 rst asserted asynchronously mid-block (between edges) -> o_valid drops immediately, o_last=0; after release only a new block produces output.
REQ-037 DEPTH=4, DATA_W=8, random i_ready -> output stream equals input blocks word 0..3 in order, o_last every 4th accepted word.

Source files
------------

// File: rtl/buffer_drain_pkg.sv
// Shared definitions for the block drainer: FSM encoding and counter sizing.
package buffer_drain_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } drain_state_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/drain_ctr.sv
// Word index counter for the drainer: reset by load/clear, saturates at DEPTH-1.
module drain_ctr
    import buffer_drain_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CntW  = cnt_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            load,
    input  logic            step,
    output logic [CntW-1:0] o_cnt,
    output logic            o_last
);

    localparam logic [CntW-1:0] LastIdx = CntW'(DEPTH - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || load) begin
            cnt_d = '0;
        end else if (step && (cnt_q != LastIdx)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_last = (cnt_q == LastIdx);

endmodule

// File: rtl/buffer_drain.sv
// Parallel-in/serial-out drainer: holds one DEPTH-word block and emits it word 0 first.
module buffer_drain
    import buffer_drain_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [DATA_W*DEPTH-1:0] i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_last
);

    localparam int unsigned CntW = cnt_width(DEPTH);

    drain_state_e state_q, state_d;

    logic [DEPTH-1:0][DATA_W-1:0] block_q, block_d;
    logic [CntW-1:0]              cnt;
    logic                         ctr_last;
    logic                         accept;
    logic                         step;

    assign accept = i_valid && o_ready;
    assign step   = o_valid && i_ready;

    drain_ctr #(
        .DEPTH (DEPTH),
        .CntW  (CntW)
    ) u_ctr (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .load   (accept),
        .step   (step),
        .o_cnt  (cnt),
        .o_last (ctr_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (accept) state_d = StSend;
                // Last word leaving with no refill drops back to idle.
                StSend: if (i_ready && ctr_last && !accept) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        o_valid = 1'b0;
        o_last  = 1'b0;
        o_ready = 1'b0;
        unique case (state_q)
            StIdle: o_ready = !clear;
            StSend: begin
                o_valid = 1'b1;
                o_last  = ctr_last;
                o_ready = !clear && i_ready && ctr_last;
            end
            default: o_ready = 1'b0;
        endcase
        o_data = block_q[cnt];
    end

    assign block_d = accept ? i_data : block_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_q <= '0;
        end else begin
            block_q <= block_d;
        end
    end

endmodule

// File: tb/tb_buffer_drain.sv
// Scoreboard bench: directed DEPTH=2/DATA_W=32 cases and random DEPTH=4/DATA_W=8 traffic.
module tb_buffer_drain;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_clear = 1'b0, a_ivalid = 1'b0, a_iready = 1'b0;
    logic [63:0] a_data = '0;
    logic        a_oready, a_ovalid, a_olast;
    logic [31:0] a_odata;

    logic        b_clear = 1'b0, b_ivalid = 1'b0, b_iready = 1'b0;
    logic [31:0] b_data = '0;
    logic        b_oready, b_ovalid, b_olast;
    logic [7:0]  b_odata;

    word_t qa[$];
    word_t qb[$];
    int    held_a = 0;
    int    held_b = 0;
    int    n_cmp  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    buffer_drain #(.DATA_W(32), .DEPTH(2)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .clear   (a_clear),
        .i_data  (a_data),
        .i_valid (a_ivalid),
        .o_ready (a_oready),
        .o_data  (a_odata),
        .o_valid (a_ovalid),
        .i_ready (a_iready),
        .o_last  (a_olast)
    );

    buffer_drain #(.DATA_W(8), .DEPTH(4)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .clear   (b_clear),
        .i_data  (b_data),
        .i_valid (b_ivalid),
        .o_ready (b_oready),
        .o_data  (b_odata),
        .o_valid (b_ovalid),
        .i_ready (b_iready),
        .o_last  (b_olast)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: every accepted output word must match the head of its scoreboard.
    always @(negedge clk) begin
        if (a_ovalid === 1'b1 && a_iready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_word", 64'(a_odata), 64'hDEAD);
            end else begin
                word_t e;
                e = qa.pop_front();
                check("a_data", 64'(a_odata), 64'(e.data));
                check("a_last", 64'(a_olast), 64'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        if (b_ovalid === 1'b1 && b_iready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_word", 64'(b_odata), 64'hDEAD);
            end else begin
                word_t e;
                e = qb.pop_front();
                check("b_data", 64'(b_odata), 64'(e.data));
                check("b_last", 64'(b_olast), 64'(e.last));
            end
        end
    end

    // One clock of stimulus on instance sel, plus the reference model step for it.
    task automatic cycle(input bit sel, input bit v, input logic [63:0] blk,
                         input bit rdy, input bit clr);
        int    h;
        int    d;
        bit    exp_valid;
        bit    exp_ready;
        word_t w;
        @(posedge clk);
        #1;
        if (!sel) begin
            a_ivalid = v; a_data = blk; a_iready = rdy; a_clear = clr;
        end else begin
            b_ivalid = v; b_data = blk[31:0]; b_iready = rdy; b_clear = clr;
        end
        @(negedge clk);
        #1;
        h = sel ? held_b : held_a;
        d = sel ? 4 : 2;
        exp_valid = (h > 0);
        exp_ready = !clr && ((h == 0) || (h == 1 && rdy));
        if (!sel) begin
            check("a_o_valid", 64'(a_ovalid), 64'(exp_valid));
            check("a_o_ready", 64'(a_oready), 64'(exp_ready));
            if (exp_valid && !rdy && qa.size() > 0) begin
                check("a_hold_data", 64'(a_odata), 64'(qa[0].data));
                check("a_hold_last", 64'(a_olast), 64'(qa[0].last));
            end
        end else begin
            check("b_o_valid", 64'(b_ovalid), 64'(exp_valid));
            check("b_o_ready", 64'(b_oready), 64'(exp_ready));
            if (exp_valid && !rdy && qb.size() > 0) begin
                check("b_hold_data", 64'(b_odata), 64'(qb[0].data));
                check("b_hold_last", 64'(b_olast), 64'(qb[0].last));
            end
        end
        if (clr) begin
            h = 0;
            if (!sel) qa.delete(); else qb.delete();
        end else begin
            if (exp_valid && rdy) h--;
            if (exp_ready && v) begin
                h += d;
                for (int k = 0; k < d; k++) begin
                    w.data = sel ? 32'(blk[k*8 +: 8]) : blk[k*32 +: 32];
                    w.last = (k == d - 1);
                    if (!sel) qa.push_back(w); else qb.push_back(w);
                end
            end
        end
        if (!sel) held_a = h; else held_b = h;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] blk1;
        logic [63:0] blk2;
        blk1 = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
        blk2 = {32'h2222_2222, 32'h1111_1111};

        #12;
        check("rst_a_valid", 64'(a_ovalid), 64'd0);
        check("rst_a_last",  64'(a_olast),  64'd0);
        check("rst_a_data",  64'(a_odata),  64'd0);
        check("rst_a_ready", 64'(a_oready), 64'd1);
        check("rst_b_valid", 64'(b_ovalid), 64'd0);
        check("rst_b_last",  64'(b_olast),  64'd0);
        check("rst_b_data",  64'(b_odata),  64'd0);
        check("rst_b_ready", 64'(b_oready), 64'd1);
        #1 rst = 1'b0;

        // Single block, free-flowing downstream.
        cycle(0, 1, blk1, 1, 0);
        repeat (3) cycle(0, 0, '0, 1, 0);

        // Back-to-back blocks, refill on the last-word cycle.
        cycle(0, 1, blk1, 1, 0);
        cycle(0, 0, '0, 1, 0);
        cycle(0, 1, blk2, 1, 0);
        repeat (3) cycle(0, 0, '0, 1, 0);

        // Backpressure on word 0 while a new block is offered.
        cycle(0, 1, blk1, 1, 0);
        repeat (3) cycle(0, 1, blk2, 0, 0);
        repeat (3) cycle(0, 0, '0, 1, 0);

        // Clear during word 0 with a block offered.
        cycle(0, 1, blk1, 1, 0);
        cycle(0, 1, blk2, 1, 1);
        cycle(0, 0, '0, 1, 0);
        cycle(0, 1, blk2, 1, 0);
        repeat (3) cycle(0, 0, '0, 1, 0);

        // Asynchronous reset while the last word is stalled.
        cycle(0, 1, blk1, 1, 0);
        cycle(0, 0, '0, 1, 0);
        cycle(0, 0, '0, 0, 0);
        @(posedge clk);
        #1 a_ivalid = 1'b0;
        a_iready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_a_valid", 64'(a_ovalid), 64'd0);
        check("arst_a_last",  64'(a_olast),  64'd0);
        check("arst_a_ready", 64'(a_oready), 64'd1);
        check("arst_a_data",  64'(a_odata),  64'd0);
        qa.delete();
        held_a = 0;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) cycle(0, 0, '0, 1, 0);
        cycle(0, 1, blk2, 1, 0);
        repeat (3) cycle(0, 0, '0, 1, 0);

        // Random traffic on the 4-deep, 8-bit instance.
        for (int i = 0; i < 500; i++) begin
            cycle(1, ($urandom % 100) < 60, {$urandom, $urandom},
                  ($urandom % 100) < 70, ($urandom % 60) == 0);
        end
        repeat (8) cycle(1, 0, '0, 1, 0);

        check("a_scoreboard_empty", 64'(qa.size()), 64'd0);
        check("b_scoreboard_empty", 64'(qb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
